life_array_grid: RTL and testbench
==================================

# life_array_grid

Parametrised Game-of-Life cell array: a ROWS x COLS grid with row-wide load/readback, and generation stepping done one row per clock by a single shared row-rule engine instead of per-cell logic. It replaces the fixed 16x16 tiled array and sits under the controller, which loads patterns by row, issues `step` and scans rows out for display. New features: configurable size, toroidal or dead-edge boundary, previous-generation snapshot, busy/done handshake, generation counter and still-life detection.

## Interface
- `ROWS`, 16: grid rows, 3..64.
- `COLS`, 16: grid columns (row word width), 3..64.
- `WRAP`, 1: 1 means toroidal edges; 0 means cells outside the grid are dead.
- `GEN_W`, 16: generation counter width.
- `ROW_W`, derived: $clog2(ROWS), selector width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `vali`  in  COLS  row data to write; bit c is column c.
- `vali_selector`  in  ROW_W  row index for writes.
- `write_enb`  in  1  write `vali` into current row `vali_selector`.
- `valo_selector`  in  ROW_W  row index for reads.
- `valo`  out  COLS  current-generation row `valo_selector` (combinational read).
- `valo_prev`  out  COLS  previous-generation row `valo_selector` (combinational read).
- `step`  in  1  request one generation.
- `busy`  out  1  generation in progress.
- `step_done`  out  1  one-cycle pulse when a generation completes.
- `stable`  out  1  last completed generation equalled its predecessor.
- `gen_count`  out  GEN_W  completed generations since reset.

## Operation
- Storage: `cur[ROWS]` and `prev[ROWS]` registers, COLS bits each.
- Rule B3/S23. A dead cell with exactly 3 live neighbours is born. A live cell with 2 or 3 live neighbours survives. All other cells are dead.
- FSM states:
  - IDLE: `step` goes to SNAP.
  - SNAP: `prev <= cur`, row counter r is set to 0, go to CALC.
  - CALC: `cur[r] <= rule(prev[r-1], prev[r], prev[r+1])`, r increments. Go to IDLE after r = ROWS-1.
- Neighbour rows and columns: with WRAP=1, indices are taken mod ROWS/COLS. With WRAP=0, out-of-range rows and columns read as 0.
- Stability check: during CALC, the flag `eq` accumulates the AND of (new row == prev row) across all rows.
- On the CALC to IDLE transition:
  - `stable <= eq`.
  - `gen_count` increments; it wraps from 2^GEN_W-1 to 0.
  - `step_done` pulses.
- Writes: applied only in IDLE. Ignored during SNAP and CALC. A write never touches `prev`. Any accepted write clears `stable`.
- `step` while busy is ignored; it is not queued.
- `step` and `write_enb` in the same IDLE cycle: the write lands first, so SNAP includes the written row.
- Selector >= ROWS: the read returns 0 and the write is ignored.
- Reset (also mid-generation, which aborts it):
  - FSM goes to IDLE; `cur` and `prev` are all 0.
  - `busy`=0, `step_done`=0, `stable`=0, `gen_count`=0.

## Timing
- `step` is sampled high in IDLE at edge T.
- `busy` is 1 from after edge T until after edge T+ROWS+1, i.e. ROWS+1 cycles.
- `step_done`, `stable` and `gen_count` update after edge T+ROWS+1; `step_done` is high for exactly one cycle.
- Minimum step-to-step period is ROWS+2 cycles. `step` is accepted in the same cycle `step_done` is high.
- During CALC, `valo` shows a mix of old and new rows. Only read after `step_done`, or whenever `busy` is 0.
- Writes take effect after the sampling edge; a read of the same row reflects the new data next cycle.

## Structure
- `life_pkg`: FSM state enum (IDLE, SNAP, CALC), rule constants (BIRTH=3, SURVIVE_LO=2, SURVIVE_HI=3).
- Sub-module `life_row_next`, combinational:
  - Parameters COLS, WRAP.
  - Inputs: north, centre and south rows.
  - Output: next row.
  - Instantiated once.

## Test plan
All with ROWS=COLS=16.
- Blinker: row5=16'h0070, step → after `step_done`, rows 4,5,6 = 16'h0020 and `valo_prev` row5=16'h0070. Step again → row5=16'h0070 and `gen_count`=2.
- Still life: rows 3,4 = 16'h0018, step → rows unchanged, `stable`=1. Then write any row → `stable`=0.
- Edges, row0=16'h8003:
  - WRAP=1, step → rows 15,0,1 = 16'h0001.
  - WRAP=0, step → entire grid 0.
- Handshake: step at T → `busy` high for 17 cycles, `step_done` high exactly at cycle T+18. A second `step` and a write of 16'hFFFF at T+5 are ignored; `gen_count`=1.
- Reset mid-CALC (T+8) → next cycle `busy`=0, all rows 0, `gen_count`=0, no `step_done`.
- Same-cycle write row2=16'h0007 plus step → result computed from the written row: rows 1,2,3 = 16'h0002.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and B3/S23 rule helper for the
// life cell array and its row engine.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SNAP,
    CALC
  } state_t;

  localparam logic [3:0] BIRTH      = 4'd3;
  localparam logic [3:0] SURVIVE_LO = 4'd2;
  localparam logic [3:0] SURVIVE_HI = 4'd3;

  // n/c/s are 3-bit windows; c[1] is the cell itself
  function automatic logic rule_cell(
    input logic [2:0] n,
    input logic [2:0] c,
    input logic [2:0] s
  );
    logic [3:0] w_cnt;
    w_cnt = 4'(n[0]) + 4'(n[1]) + 4'(n[2])
          + 4'(c[0]) + 4'(c[2])
          + 4'(s[0]) + 4'(s[1]) + 4'(s[2]);
    if (c[1])
      return (w_cnt >= SURVIVE_LO) &&
             (w_cnt <= SURVIVE_HI);
    return w_cnt == BIRTH;
  endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation row from the
// north, centre and south rows of the snapshot.
module life_row_next
  import life_pkg::*;
#(
  parameter int COLS = 16,
  parameter int WRAP = 1
) (
  input  logic [COLS-1:0] i_north,
  input  logic [COLS-1:0] i_centre,
  input  logic [COLS-1:0] i_south,
  output logic [COLS-1:0] o_next
);

  // rows padded by one column each side;
  // pad is the opposite edge or dead
  logic [COLS+1:0] w_n;
  logic [COLS+1:0] w_c;
  logic [COLS+1:0] w_s;

  if (WRAP != 0) begin : g_wrap
    assign w_n = {i_north[0], i_north,
                  i_north[COLS-1]};
    assign w_c = {i_centre[0], i_centre,
                  i_centre[COLS-1]};
    assign w_s = {i_south[0], i_south,
                  i_south[COLS-1]};
  end else begin : g_dead
    assign w_n = {1'b0, i_north, 1'b0};
    assign w_c = {1'b0, i_centre, 1'b0};
    assign w_s = {1'b0, i_south, 1'b0};
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign o_next[c] = rule_cell(w_n[c+2:c],
                                 w_c[c+2:c],
                                 w_s[c+2:c]);
  end

endmodule

// File: rtl/life_array_grid.sv
// Game-of-Life grid: row load/readback, one
// row per clock generation stepping.
module life_array_grid
  import life_pkg::*;
#(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int WRAP  = 1,
  parameter int GEN_W = 16,
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [COLS-1:0]  vali,
  input  logic [ROW_W-1:0] vali_selector,
  input  logic             write_enb,
  input  logic [ROW_W-1:0] valo_selector,
  output logic [COLS-1:0]  valo,
  output logic [COLS-1:0]  valo_prev,
  input  logic             step,
  output logic             busy,
  output logic             step_done,
  output logic             stable,
  output logic [GEN_W-1:0] gen_count
);

  localparam logic [ROW_W-1:0] LAST =
    ROW_W'(ROWS - 1);
  localparam logic [ROW_W:0] NROWS =
    (ROW_W+1)'(ROWS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [COLS-1:0]  r_cur  [ROWS];
  logic [COLS-1:0]  r_prev [ROWS];
  logic [ROW_W-1:0] r_row;
  logic             r_eq;
  logic             r_stable;
  logic             r_done;
  logic [GEN_W-1:0] r_gen;
  logic             w_busy;
  logic             w_last;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_row_eq;
  logic [COLS-1:0]  w_north;
  logic [COLS-1:0]  w_south;
  logic [COLS-1:0]  w_next;

  assign w_last   = r_row == LAST;
  assign w_wr_ok  = {1'b0, vali_selector} < NROWS;
  assign w_rd_ok  = {1'b0, valo_selector} < NROWS;
  assign w_row_eq = w_next == r_prev[r_row];

  assign valo      = w_rd_ok ?
                     r_cur[valo_selector] : '0;
  assign valo_prev = w_rd_ok ?
                     r_prev[valo_selector] : '0;
  assign busy      = w_busy;
  assign step_done = r_done;
  assign stable    = r_stable;
  assign gen_count = r_gen;

  // neighbour rows of the row being computed
  always_comb begin
    w_north = '0;
    w_south = '0;
    if (r_row == '0) begin
      if (WRAP != 0) w_north = r_prev[LAST];
    end else begin
      w_north = r_prev[r_row - 1'b1];
    end
    if (w_last) begin
      if (WRAP != 0) w_south = r_prev[0];
    end else begin
      w_south = r_prev[r_row + 1'b1];
    end
  end

  life_row_next #(
    .COLS (COLS),
    .WRAP (WRAP)
  ) u_row_next (
    .i_north  (w_north),
    .i_centre (r_prev[r_row]),
    .i_south  (w_south),
    .o_next   (w_next)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and busy flag
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    unique case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (step) w_state_nxt = SNAP;
      end
      SNAP: w_state_nxt = CALC;
      CALC: if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // grid storage, row engine writeback, status
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) begin
        r_cur[i]  <= '0;
        r_prev[i] <= '0;
      end
      r_row    <= '0;
      r_eq     <= 1'b0;
      r_stable <= 1'b0;
      r_done   <= 1'b0;
      r_gen    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (write_enb && w_wr_ok) begin
            r_cur[vali_selector] <= vali;
            r_stable <= 1'b0;
          end
        end
        SNAP: begin
          for (int i = 0; i < ROWS; i++)
            r_prev[i] <= r_cur[i];
          r_row <= '0;
          r_eq  <= 1'b1;
        end
        CALC: begin
          r_cur[r_row] <= w_next;
          r_eq  <= r_eq & w_row_eq;
          r_row <= r_row + 1'b1;
          if (w_last) begin
            r_stable <= r_eq & w_row_eq;
            r_gen    <= r_gen + 1'b1;
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_life_array_grid.sv
// Scoreboard bench: toroidal and dead-edge grids
// driven together against a cell-level model.
module tb_life_array_grid;

  typedef struct packed {
    logic [255:0] cur;
    logic [255:0] prv;
    logic         stb;
    logic [15:0]  gen;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] vali;
  logic [3:0]  vali_selector;
  logic        write_enb;
  logic [3:0]  valo_selector;
  logic        step;
  logic [15:0] valo_w, prev_w, gen_w;
  logic [15:0] valo_n, prev_n, gen_n;
  logic        busy_w, done_w, stb_w;
  logic        busy_n, done_n, stb_n;

  life_array_grid #(
    .ROWS(16), .COLS(16), .WRAP(1), .GEN_W(16)
  ) u_dut_w (
    .clk           (clk),
    .reset         (reset),
    .vali          (vali),
    .vali_selector (vali_selector),
    .write_enb     (write_enb),
    .valo_selector (valo_selector),
    .valo          (valo_w),
    .valo_prev     (prev_w),
    .step          (step),
    .busy          (busy_w),
    .step_done     (done_w),
    .stable        (stb_w),
    .gen_count     (gen_w)
  );

  life_array_grid #(
    .ROWS(16), .COLS(16), .WRAP(0), .GEN_W(16)
  ) u_dut_n (
    .clk           (clk),
    .reset         (reset),
    .vali          (vali),
    .vali_selector (vali_selector),
    .write_enb     (write_enb),
    .valo_selector (valo_selector),
    .valo          (valo_n),
    .valo_prev     (prev_n),
    .step          (step),
    .busy          (busy_n),
    .step_done     (done_n),
    .stable        (stb_n),
    .gen_count     (gen_n)
  );

  always #50 clk = ~clk;

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t q_w[$];
  exp_t q_n[$];

  logic [255:0] m_w, m_n, mp_w, mp_n;
  logic         ms_w, ms_n;
  logic [15:0]  mg;

  logic [255:0] cw, pw, cn, pn, g;
  int           nd_abort;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] life_next(
    input logic [255:0] gi,
    input bit           wrap
  );
    logic [255:0] o;
    int cnt, rr, cc;
    o = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + 16) % 16;
              cc = (cc + 16) % 16;
            end else if (rr < 0 || rr > 15 ||
                         cc < 0 || cc > 15) begin
              continue;
            end
            if (gi[rr*16+cc]) cnt++;
          end
        if (gi[r*16+c])
          o[r*16+c] = (cnt == 2 || cnt == 3);
        else
          o[r*16+c] = (cnt == 3);
      end
    return o;
  endfunction

  task automatic check(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h",
               tag, obs, exp);
      $error("assertion on %s", tag);
    end
  endtask

  task automatic model_clear();
    m_w = '0; m_n = '0; mp_w = '0; mp_n = '0;
    ms_w = 1'b0; ms_n = 1'b0; mg = '0;
    q_w.delete();
    q_n.delete();
  endtask

  task automatic read_grids(
    output logic [255:0] ocw, opw, ocn, opn
  );
    for (int r = 0; r < 16; r++) begin
      valo_selector = 4'(r);
      #1;
      ocw[r*16 +: 16] = valo_w;
      opw[r*16 +: 16] = prev_w;
      ocn[r*16 +: 16] = valo_n;
      opn[r*16 +: 16] = prev_n;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; step = 1'b0; write_enb = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic write_row(input int r,
                           input logic [15:0] v);
    @(negedge clk);
    vali = v; vali_selector = 4'(r);
    write_enb = 1'b1;
    @(negedge clk);
    write_enb = 1'b0;
    m_w[r*16 +: 16] = v;
    m_n[r*16 +: 16] = v;
    ms_w = 1'b0; ms_n = 1'b0;
  endtask

  // called at a negedge; step is sampled next edge
  task automatic begin_step(input bit wr,
                            input int r,
                            input logic [15:0] v);
    step = 1'b1;
    if (wr) begin
      vali = v; vali_selector = 4'(r);
      write_enb = 1'b1;
      m_w[r*16 +: 16] = v;
      m_n[r*16 +: 16] = v;
    end
    mp_w = m_w; m_w = life_next(m_w, 1'b1);
    mp_n = m_n; m_n = life_next(m_n, 1'b0);
    ms_w = (m_w == mp_w);
    ms_n = (m_n == mp_n);
    mg = mg + 16'd1;
    q_w.push_back('{m_w, mp_w, ms_w, mg});
    q_n.push_back('{m_n, mp_n, ms_n, mg});
  endtask

  task automatic compare_pop();
    exp_t ew, en;
    logic [255:0] a, b, c, d;
    if (q_w.size() == 0 || q_n.size() == 0) begin
      n_checks++; n_err++;
      $display("FAIL scoreboard: observed done, expected none");
      return;
    end
    ew = q_w.pop_front();
    en = q_n.pop_front();
    read_grids(a, b, c, d);
    check("cur_wrap", a, ew.cur);
    check("prev_wrap", b, ew.prv);
    check("stable_wrap", 256'(stb_w), 256'(ew.stb));
    check("gen_wrap", 256'(gen_w), 256'(ew.gen));
    check("cur_dead", c, en.cur);
    check("prev_dead", d, en.prv);
    check("stable_dead", 256'(stb_n), 256'(en.stb));
    check("gen_dead", 256'(gen_n), 256'(en.gen));
  endtask

  task automatic run_gen(input bit inject,
                         input bit chain);
    int nb_w = 0, nb_n = 0, nd_w = 0, nd_n = 0;
    int di_w = -1, di_n = -1;
    bit got = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      step = 1'b0; write_enb = 1'b0;
      if (inject && i == 4) begin
        step = 1'b1; write_enb = 1'b1;
        vali = 16'hFFFF; vali_selector = 4'd6;
      end
      if (busy_w) nb_w++;
      if (busy_n) nb_n++;
      if (done_w) begin nd_w++; di_w = i; end
      if (done_n) begin nd_n++; di_n = i; end
      if ((done_w || done_n) && !got) begin
        got = 1'b1;
        compare_pop();
        if (chain) begin
          begin_step(1'b0, 0, 16'h0);
          break;
        end
      end
    end
    if (!got) begin
      void'(q_w.pop_front());
      void'(q_n.pop_front());
    end
    check("busy_cycles_wrap", 256'(nb_w), 256'(17));
    check("busy_cycles_dead", 256'(nb_n), 256'(17));
    check("done_pos_wrap", 256'(di_w), 256'(17));
    check("done_pos_dead", 256'(di_n), 256'(17));
    check("done_count_wrap", 256'(nd_w), 256'(1));
    check("done_count_dead", 256'(nd_n), 256'(1));
  endtask

  initial begin
    reset = 1'b1; step = 1'b0; write_enb = 1'b0;
    vali = '0; vali_selector = '0;
    valo_selector = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();

    // reset state
    read_grids(cw, pw, cn, pn);
    check("rst_cur_wrap", cw, '0);
    check("rst_prev_wrap", pw, '0);
    check("rst_cur_dead", cn, '0);
    check("rst_prev_dead", pn, '0);
    check("rst_busy", 256'({busy_w, busy_n}), '0);
    check("rst_done", 256'({done_w, done_n}), '0);
    check("rst_stable", 256'({stb_w, stb_n}), '0);
    check("rst_gen", 256'({gen_w, gen_n}), '0);

    // blinker, second step issued in the done cycle
    write_row(5, 16'h0070);
    begin_step(1'b0, 0, 16'h0);
    run_gen(1'b0, 1'b1);
    run_gen(1'b0, 1'b0);
    read_grids(cw, pw, cn, pn);
    g = '0;
    g[5*16 +: 16] = 16'h0070;
    check("blinker_cur", cw, g);
    g = '0;
    g[4*16 +: 16] = 16'h0020;
    g[5*16 +: 16] = 16'h0020;
    g[6*16 +: 16] = 16'h0020;
    check("blinker_prev", pw, g);
    check("blinker_gen", 256'(gen_w), 256'(2));

    // still life block, then a write clears stable
    do_reset();
    write_row(3, 16'h0018);
    write_row(4, 16'h0018);
    begin_step(1'b0, 0, 16'h0);
    run_gen(1'b0, 1'b0);
    check("block_stable", 256'({stb_w, stb_n}),
          256'(2'b11));
    write_row(10, 16'h0000);
    check("write_clears_stable",
          256'({stb_w, stb_n}), '0);

    // edge handling
    do_reset();
    write_row(0, 16'h8003);
    begin_step(1'b0, 0, 16'h0);
    run_gen(1'b0, 1'b0);
    read_grids(cw, pw, cn, pn);
    g = '0;
    g[15*16 +: 16] = 16'h0001;
    g[0 +: 16]     = 16'h0001;
    g[1*16 +: 16]  = 16'h0001;
    check("edge_wrap", cw, g);
    check("edge_dead", cn, '0);

    // step and write while busy are ignored
    do_reset();
    write_row(5, 16'h0070);
    begin_step(1'b0, 0, 16'h0);
    run_gen(1'b1, 1'b0);
    check("ignored_gen", 256'(gen_w), 256'(1));
    read_grids(cw, pw, cn, pn);
    check("ignored_row6", 256'(cw[6*16 +: 16]),
          256'(16'h0020));

    // reset in the middle of CALC
    do_reset();
    write_row(5, 16'h0070);
    begin_step(1'b0, 0, 16'h0);
    nd_abort = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      step = 1'b0;
      if (i == 7) reset = 1'b1;
      if (i == 8) begin
        reset = 1'b0;
        model_clear();
        check("abort_busy", 256'({busy_w, busy_n}),
              '0);
        check("abort_gen", 256'({gen_w, gen_n}), '0);
        read_grids(cw, pw, cn, pn);
        check("abort_cur", cw | cn, '0);
        check("abort_prev", pw | pn, '0);
      end
      if (done_w || done_n) nd_abort++;
    end
    check("abort_no_done", 256'(nd_abort), '0);

    // write and step in the same cycle
    do_reset();
    @(negedge clk);
    begin_step(1'b1, 2, 16'h0007);
    run_gen(1'b0, 1'b0);
    read_grids(cw, pw, cn, pn);
    g = '0;
    g[1*16 +: 16] = 16'h0002;
    g[2*16 +: 16] = 16'h0002;
    g[3*16 +: 16] = 16'h0002;
    check("same_cycle_wrap", cw, g);
    check("same_cycle_dead", cn, g);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
